// File: rtl/tone_period_detector.sv
// ============================================================================
//  Module      : tone_period_detector
//  Description : Measures the period of a square-wave tone in a signed sample
//                stream, with hysteresis, lock qualification and silence timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_period_detector #(
    parameter logic signed [31:0] THRESH     = 32'sd100000000,
    parameter logic        [31:0] MAX_PERIOD = 32'd4000000,
    parameter logic        [31:0] MATCH_TOL  = 32'd8,
    parameter logic        [3:0]  LOCK_COUNT = 4'd3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [31:0] audio_in,
    input  logic               sample_valid,
    output logic        [31:0] period_out,
    output logic        [31:0] hz_out,
    output logic               note_detected,
    output logic               period_valid
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SEEK    = 2'd1;
    localparam logic [1:0] c_ST_MEASURE = 2'd2;
    localparam logic [1:0] c_ST_LOCKED  = 2'd3;

    localparam logic c_POL_NEG = 1'b0;
    localparam logic c_POL_POS = 1'b1;

    logic [1:0]  r_state;
    logic        r_pol;
    logic [31:0] r_counter;
    logic [3:0]  r_match_cnt;
    logic [31:0] r_last_period;
    logic [31:0] r_period_out;
    logic [31:0] r_hz_out;
    logic        r_note;
    logic        r_period_valid;

    logic        w_is_pos;
    logic        w_is_neg;
    logic        w_edge;
    logic [31:0] w_captured;
    logic        w_diff_ok;
    logic        w_match;
    logic [3:0]  w_match_next;
    logic [31:0] w_cnt_inc;
    logic        w_timeout;

    assign w_is_pos = (audio_in >= THRESH);
    assign w_is_neg = (audio_in <= -THRESH);

    // Polarity is only meaningful once a sample has crossed a threshold.
    assign w_edge = sample_valid && (r_state != c_ST_IDLE) &&
                    (r_pol == c_POL_NEG) && w_is_pos;

    assign w_captured = r_counter + 32'd1;

    // Ordered subtraction keeps the tolerance check free of wrap-around.
    assign w_diff_ok = (w_captured >= r_last_period) ?
                       ((w_captured - r_last_period) <= MATCH_TOL) :
                       ((r_last_period - w_captured) <= MATCH_TOL);

    assign w_match      = (r_match_cnt != 4'd0) && w_diff_ok;
    assign w_match_next = !w_match ? 4'd1 :
                          (r_match_cnt >= LOCK_COUNT) ? LOCK_COUNT :
                          r_match_cnt + 4'd1;

    assign w_cnt_inc = (r_counter >= MAX_PERIOD) ? MAX_PERIOD : r_counter + 32'd1;
    assign w_timeout = (w_cnt_inc >= MAX_PERIOD);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_pol          <= c_POL_NEG;
            r_counter      <= 32'd0;
            r_match_cnt    <= 4'd0;
            r_last_period  <= 32'd0;
            r_period_out   <= 32'd0;
            r_hz_out       <= 32'd0;
            r_note         <= 1'b0;
            r_period_valid <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (sample_valid) begin
                if (w_is_pos) begin
                    r_pol <= c_POL_POS;
                end else if (w_is_neg) begin
                    r_pol <= c_POL_NEG;
                end

                case (r_state)
                    c_ST_IDLE: begin
                        if (w_is_pos || w_is_neg) begin
                            r_state <= c_ST_SEEK;
                        end
                    end
                    c_ST_SEEK: begin
                        if (w_edge) begin
                            r_counter <= 32'd0;
                            r_state   <= c_ST_MEASURE;
                        end
                    end
                    c_ST_MEASURE, c_ST_LOCKED: begin
                        if (w_edge) begin
                            r_last_period <= w_captured;
                            r_counter     <= 32'd0;
                            r_match_cnt   <= w_match_next;
                            if (r_state == c_ST_LOCKED) begin
                                if (w_match) begin
                                    r_period_out   <= w_captured;
                                    r_hz_out       <= w_captured - 32'd1;
                                    r_period_valid <= 1'b1;
                                end else begin
                                    r_note  <= 1'b0;
                                    r_state <= c_ST_MEASURE;
                                end
                            end else if (w_match_next == LOCK_COUNT) begin
                                r_state        <= c_ST_LOCKED;
                                r_note         <= 1'b1;
                                r_period_out   <= w_captured;
                                r_hz_out       <= w_captured - 32'd1;
                                r_period_valid <= 1'b1;
                            end
                        end else if (w_timeout) begin
                            // Silence: drop lock but keep polarity for a clean restart.
                            r_state      <= c_ST_SEEK;
                            r_counter    <= w_cnt_inc;
                            r_match_cnt  <= 4'd0;
                            r_note       <= 1'b0;
                            r_period_out <= 32'd0;
                            r_hz_out     <= 32'd0;
                        end else begin
                            r_counter <= w_cnt_inc;
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign period_out    = r_period_out;
    assign hz_out        = r_hz_out;
    assign note_detected = r_note;
    assign period_valid  = r_period_valid;

endmodule

`default_nettype wire

// File: tb/tb_tone_period_detector.sv
// ============================================================================
//  Module      : tb_tone_period_detector
//  Description : Directed scoreboard bench for tone_period_detector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tone_period_detector;

    localparam logic signed [31:0] c_AMP = 32'sd200000000;

    logic               clock;
    logic               reset;
    logic signed [31:0] audio_in;
    logic               sample_valid;
    logic        [31:0] period_out;
    logic        [31:0] hz_out;
    logic               note_detected;
    logic               period_valid;

    int n_vec  = 0;
    int n_miss = 0;
    bit noise_mode = 0;
    bit gap_mode   = 0;
    logic [31:0] exp_q[$];

    tone_period_detector #(.MAX_PERIOD(32'd3000)) dut (
        .clock        (clock),
        .reset        (reset),
        .audio_in     (audio_in),
        .sample_valid (sample_valid),
        .period_out   (period_out),
        .hz_out       (hz_out),
        .note_detected(note_detected),
        .period_valid (period_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Every capture pulse must match the next queued period.
    always @(negedge clock) begin
        if (period_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_pulse: got period %0d expected no pulse", period_out);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_period", period_out, e);
                check("sb_hz", hz_out, e - 32'd1);
            end
        end
    end

    task automatic send(input logic signed [31:0] s, input logic v);
        audio_in     = s;
        sample_valid = v;
        @(posedge clock);
        #1;
    endtask

    task automatic half(input logic signed [31:0] level, input int n);
        logic signed [31:0] nz;
        for (int i = 0; i < n; i++) begin
            nz = noise_mode ? ($signed(32'($urandom_range(100000000, 0))) - 32'sd50000000) : 32'sd0;
            send(level + nz, 1'b1);
            if (gap_mode) send(-level, 1'b0);
        end
    endtask

    // Low half then high half; the rise opens the high half.
    task automatic cyc(input int lo, input int hi);
        half(-c_AMP, lo);
        half(c_AMP, hi);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) send(32'sd0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        audio_in     = 32'sd0;
        sample_valid = 1'b0;
        @(posedge clock);
        #1;
        do_reset(3);
        check("rst_period", period_out, 32'd0);
        check("rst_hz", hz_out, 32'd0);
        check("rst_note", {31'd0, note_detected}, 32'd0);
        check("rst_pv", {31'd0, period_valid}, 32'd0);

        // Steady 1001-sample tone: lock on the fourth rising edge.
        for (int i = 0; i < 3; i++) cyc(501, 500);
        check("pre_lock_note", {31'd0, note_detected}, 32'd0);
        half(-c_AMP, 501);
        exp_q.push_back(32'd1001);
        send(c_AMP, 1'b1);
        check("lock_note", {31'd0, note_detected}, 32'd1);
        check("lock_period", period_out, 32'd1001);
        check("lock_hz", hz_out, 32'd1000);
        half(c_AMP, 499);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(32'd1001);
            cyc(501, 500);
        end

        // Jitter within tolerance keeps lock and tracks each capture.
        exp_q.push_back(32'd1005); cyc(505, 500);
        exp_q.push_back(32'd1001); cyc(501, 500);
        exp_q.push_back(32'd1005); cyc(505, 500);
        check("jit_note", {31'd0, note_detected}, 32'd1);
        check("jit_period", period_out, 32'd1005);

        // Jump to 1500 breaks lock; outputs hold until re-lock.
        cyc(1000, 500);
        check("jump_note", {31'd0, note_detected}, 32'd0);
        check("jump_hold", period_out, 32'd1005);
        cyc(1000, 500);
        check("jump_still", {31'd0, note_detected}, 32'd0);
        exp_q.push_back(32'd1500);
        cyc(1000, 500);
        check("relock_note", {31'd0, note_detected}, 32'd1);
        check("relock_hz", hz_out, 32'd1499);

        // Note released: silence times out after MAX_PERIOD samples.
        for (int i = 0; i < 2000; i++) send(32'sd0, 1'b1);
        check("silence_hold", {31'd0, note_detected}, 32'd1);
        for (int i = 0; i < 1000; i++) send(32'sd0, 1'b1);
        check("to_note", {31'd0, note_detected}, 32'd0);
        check("to_period", period_out, 32'd0);
        check("to_hz", hz_out, 32'd0);
        for (int i = 0; i < 3; i++) cyc(501, 500);
        check("restart_pre", {31'd0, note_detected}, 32'd0);
        exp_q.push_back(32'd1001);
        cyc(501, 500);
        check("restart_lock", {31'd0, note_detected}, 32'd1);

        // 200-sample tone with noise that never crosses the threshold gap.
        do_reset(2);
        noise_mode = 1;
        for (int i = 0; i < 3; i++) cyc(100, 100);
        exp_q.push_back(32'd200); cyc(100, 100);
        exp_q.push_back(32'd200); cyc(100, 100);
        check("noise_period", period_out, 32'd200);
        check("noise_note", {31'd0, note_detected}, 32'd1);
        do_reset(2);
        for (int i = 0; i < 400; i++)
            send($signed(32'($urandom_range(100000000, 0))) - 32'sd50000000, 1'b1);
        noise_mode = 0;
        check("quiet_note", {31'd0, note_detected}, 32'd0);
        check("quiet_period", period_out, 32'd0);

        // Gaps in sample_valid carry opposite-polarity junk that must be ignored.
        do_reset(2);
        gap_mode = 1;
        for (int i = 0; i < 3; i++) cyc(150, 150);
        check("gap_pre", {31'd0, note_detected}, 32'd0);
        exp_q.push_back(32'd300); cyc(150, 150);
        exp_q.push_back(32'd300); cyc(150, 150);
        gap_mode = 0;
        check("gap_period", period_out, 32'd300);
        check("gap_hz", hz_out, 32'd299);

        // Reset while locked wins over a valid sample on the same edge.
        reset = 1'b1;
        send(-c_AMP, 1'b1);
        reset = 1'b0;
        check("mid_rst_period", period_out, 32'd0);
        check("mid_rst_hz", hz_out, 32'd0);
        check("mid_rst_note", {31'd0, note_detected}, 32'd0);
        check("mid_rst_pv", {31'd0, period_valid}, 32'd0);
        for (int i = 0; i < 3; i++) cyc(150, 150);
        check("post_rst_pre", {31'd0, note_detected}, 32'd0);
        exp_q.push_back(32'd300);
        cyc(150, 150);
        check("post_rst_lock", {31'd0, note_detected}, 32'd1);

        for (int i = 0; i < 4; i++) send(32'sd0, 1'b0);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tone_period_detector.md
Name: tone_period_detector

Overview:
- Receiver-side counterpart to the square-wave tone generators: takes a signed 32-bit audio sample stream and measures the period of the tone it contains.
- Reports the period both as a sample count and as the generator's `hz` code, so a captured note can be replayed directly.
- Sits on the audio sample path feeding the record/compare logic. It applies hysteresis and a lock qualifier to reject noise and silence.

Parameters:
- THRESH, 32'sd100000000, hysteresis level. A sample ≥ +THRESH is positive; a sample ≤ −THRESH is negative.
- MAX_PERIOD, 32'd4000000, timeout in valid samples. No rising edge within this many samples means silence.
- MATCH_TOL, 32'd8, maximum absolute difference between consecutive periods that still counts as a match.
- LOCK_COUNT, 4'd3, number of consecutive matching periods required for lock.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- audio_in  input  32  signed two's-complement sample
- sample_valid  input  1  audio_in is valid this cycle; all logic advances only when this is high
- period_out  output  32  last locked period, in samples
- hz_out  output  32  period_out − 1, the generator `hz` code reproducing this tone (0 when period_out is 0)
- note_detected  output  1  high while locked
- period_valid  output  1  one-cycle pulse on each locked period capture

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: period_out=0, hz_out=0, note_detected=0, period_valid=0, state=IDLE, counter=0, match_cnt=0, last_period=0.
- Reset asserted mid-operation clears everything at that edge, regardless of sample_valid.
- Polarity tracking (valid samples only):
  - Sample ≥ THRESH sets pol=POS.
  - Sample ≤ −THRESH sets pol=NEG.
  - Any sample in between, including 0, holds pol.
  - Comparisons are signed.
- Rising edge: a valid sample that moves pol from NEG to POS.
- States:
  - IDLE: no polarity known yet. The first valid sample beyond ±THRESH sets pol and moves to SEEK.
  - SEEK: waiting for the first rising edge. On that edge, counter←0 and move to MEASURE.
  - MEASURE: on each non-edge valid sample, counter←counter+1, saturating at MAX_PERIOD. On a rising edge:
    - captured = counter+1.
    - If match_cnt≠0 and |captured − last_period| ≤ MATCH_TOL, then match_cnt←match_cnt+1.
    - Otherwise match_cnt←1.
    - In both cases last_period←captured and counter←0.
    - If the new match_cnt equals LOCK_COUNT: move to LOCKED, note_detected←1, period_out←captured, hz_out←captured−1, period_valid pulses.
  - LOCKED: counting is the same as MEASURE. On a rising edge:
    - Match: period_out and hz_out update to the new capture and period_valid pulses.
    - Mismatch: note_detected←0, match_cnt←1, period_out and hz_out hold, move to MEASURE.
- Timeout: in MEASURE or LOCKED, when counter reaches MAX_PERIOD:
  - next state SEEK, note_detected←0, match_cnt←0, period_out←0, hz_out←0.
  - pol is kept, so the next NEG→POS edge restarts measurement.
- Period convention: a square wave of N samples per cycle yields captured=N. A generator loaded with hz=H runs its counter H..0, so its period is H+1 and hz_out=H.
- Latency: the edge sample presented at cycle k produces updated outputs visible after clock edge k, i.e. 1 cycle.
- sample_valid low: no state, counter or polarity change, and period_valid=0.
- match_cnt saturates at LOCK_COUNT. Subtraction for the tolerance check uses 33-bit or ordered compare, so there is no wrap.
- Throughput: one sample per clock. Back-to-back edges (N=2) are legal.

Test Plan:
- Square wave ±200000000, hz=1000 stimulus (period 1001), sample_valid=1 → note_detected rises one cycle after the 4th rising edge; period_out=1001, hz_out=1000, period_valid pulse once per subsequent edge.
- Periods alternating 1001/1005 (within MATCH_TOL) → lock held, period_out tracks each capture; a jump to 1500 → note_detected drops, re-locks after 3 matching 1500-sample periods, hz_out=1499.
- While locked, audio_in held at 0 (note released) → after MAX_PERIOD valid samples note_detected=0, period_out=0, state SEEK; restart tone → re-lock after 4 rising edges.
- Noise of ±50000000 superimposed on a 200-sample tone → no spurious edges, lock at period 200; pure noise below THRESH → never leaves IDLE.
- sample_valid toggling 50% during a 300-sample-period tone → period_out=300 (gaps not counted), with lock timing doubled in clocks.
- Reset asserted one cycle after lock → next cycle all outputs 0, state IDLE; a tone resumed right after reset needs the full 4-edge lock sequence again.
